// File: rtl/quantum_timer_if.sv
// -----------------------------------------------------------------------------
// quantum_timer_if
// Bundle between the processor control unit and the preemption (quantum)
// timer. Clock and reset stay as plain ports on the modules.
//
// Signals (direction seen from the timer / slave side):
//   set_quantum  in   one-cycle pulse: load quantum_in (Set Quantum instr.)
//   quantum_in   in   QWIDTH quantum value, sampled with set_quantum
//   os_mode      in   kernel/scheduler running; counting suspended
//   instr_retire in   one pulse per completed instruction
//   proc_halt    in   user process executed halt; forces a request
//   irq_ack      in   interruptionProcess (Change Context) acknowledge
//   irq          out  registered context-change request (level)
//   remaining    out  current down-counter value
//   active       out  timer in COUNT or PEND
// -----------------------------------------------------------------------------
interface quantum_timer_if #(
    parameter int QWIDTH = 16
);
    logic              set_quantum;
    logic [QWIDTH-1:0] quantum_in;
    logic              os_mode;
    logic              instr_retire;
    logic              proc_halt;
    logic              irq_ack;
    logic              irq;
    logic [QWIDTH-1:0] remaining;
    logic              active;

    // Control unit side.
    modport master (
        output set_quantum, quantum_in, os_mode, instr_retire, proc_halt, irq_ack,
        input  irq, remaining, active
    );

    // Timer side.
    modport slave (
        input  set_quantum, quantum_in, os_mode, instr_retire, proc_halt, irq_ack,
        output irq, remaining, active
    );
endinterface

// File: rtl/quantum_timer.sv
// -----------------------------------------------------------------------------
// quantum_timer
// Preemption timer for round-robin scheduling. A Set Quantum instruction
// loads the quantum; every retired user-mode instruction decrements it.
// On expiry, or when a user process halts, a context-change request (irq)
// is raised and held until the control unit acknowledges it.
//
// Ports:
//   clock    in   system clock, all state updates on the rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      quantum_timer_if.slave (see interface header)
//
// States:
//   IDLE   timer disabled, only set_quantum is honoured
//   COUNT  counting retired user-mode instructions
//   PEND   irq asserted, waiting for irq_ack
// -----------------------------------------------------------------------------
module quantum_timer #(
    parameter int QWIDTH = 16   // must match the QWIDTH of the connected interface
) (
    input  logic           clock,
    input  logic           reset_n,
    quantum_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PEND  = 2'd2
    } state_t;

    localparam logic [QWIDTH-1:0] ZERO = '0;
    localparam logic [QWIDTH-1:0] ONE  = QWIDTH'(1);

    state_t            r_state;
    logic [QWIDTH-1:0] r_count;
    logic [QWIDTH-1:0] r_quantum;

    state_t            w_state_nxt;
    logic [QWIDTH-1:0] w_count_nxt;
    logic [QWIDTH-1:0] w_quantum_nxt;
    logic [QWIDTH-1:0] w_reload;
    logic              w_user_retire;
    logic              w_user_halt;
    logic              w_irq;
    logic              w_active;

    // Events that only count while a user process is running.
    assign w_user_retire = bus.instr_retire && !bus.os_mode;
    assign w_user_halt   = bus.proc_halt    && !bus.os_mode;

    // Reload value on an acknowledge out of PEND: a simultaneous Set Quantum
    // wins over the stored quantum.
    assign w_reload = bus.set_quantum ? bus.quantum_in : r_quantum;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= ZERO;
            r_quantum <= ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_quantum <= w_quantum_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a hold default first; without it an
    // unassigned branch would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_quantum_nxt = r_quantum;

        unique case (r_state)
            IDLE: begin
                // Retire, halt and ack are meaningless while disabled.
                if (bus.set_quantum) begin
                    w_quantum_nxt = bus.quantum_in;
                    if (bus.quantum_in != ZERO) begin
                        w_count_nxt = bus.quantum_in;
                        w_state_nxt = COUNT;
                    end
                end
            end

            COUNT: begin
                if (bus.set_quantum) begin
                    // A new quantum restarts the slice; no decrement this cycle.
                    w_quantum_nxt = bus.quantum_in;
                    w_count_nxt   = bus.quantum_in;
                    if (bus.quantum_in == ZERO) begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_user_halt) begin
                    // Count is frozen so the scheduler can see what was left.
                    w_state_nxt = PEND;
                end else if (bus.irq_ack) begin
                    // Voluntary context change: the next process gets a full slice.
                    w_count_nxt = r_quantum;
                end else if (w_user_retire) begin
                    if (r_count == ONE) begin
                        w_count_nxt = ZERO;
                        w_state_nxt = PEND;
                    end else if (r_count != ZERO) begin
                        // Guarded so the counter can never wrap.
                        w_count_nxt = r_count - ONE;
                    end
                end
            end

            PEND: begin
                // Retire and halt are dropped, so one expiry gives one request.
                if (bus.set_quantum) begin
                    w_quantum_nxt = bus.quantum_in;
                end
                if (bus.irq_ack) begin
                    w_count_nxt = w_reload;
                    w_state_nxt = (w_reload != ZERO) ? COUNT : IDLE;
                end
            end

            default: begin
                // Unreachable encoding: recover to a disabled timer.
                w_state_nxt = IDLE;
                w_count_nxt = ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        w_irq    = (r_state == PEND);
        w_active = (r_state == COUNT) || (r_state == PEND);
    end

    assign bus.irq       = w_irq;
    assign bus.active    = w_active;
    assign bus.remaining = r_count;

endmodule

// File: tb/tb_quantum_timer.sv
// -----------------------------------------------------------------------------
// tb_quantum_timer
// Directed stimulus for quantum_timer. A behavioural model (remaining slice,
// stored quantum, "request pending" and "timer enabled" flags) predicts the
// outputs; a compare process checks them on every falling clock edge, and
// the directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_quantum_timer;

    localparam int QW = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    quantum_timer_if #(.QWIDTH(QW)) bus ();

    quantum_timer #(.QWIDTH(QW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int m_left;      // instructions left in the current slice
    int m_quantum;   // last quantum written by Set Quantum
    bit m_pending;   // a context-change request is outstanding
    bit m_enabled;   // timer is counting (not disabled, not pending)

    always @(posedge clock or negedge reset_n) begin
        int  left, quantum, q_new;
        bit  pending, enabled, user;
        if (!reset_n) begin
            m_left    <= 0;
            m_quantum <= 0;
            m_pending <= 1'b0;
            m_enabled <= 1'b0;
        end else begin
            left    = m_left;
            quantum = m_quantum;
            pending = m_pending;
            enabled = m_enabled;
            user    = !bus.os_mode;
            q_new   = int'(bus.quantum_in);
            if (pending) begin
                if (bus.set_quantum) quantum = q_new;
                if (bus.irq_ack) begin
                    pending = 1'b0;
                    left    = quantum;
                    enabled = (quantum > 0);
                end
            end else if (enabled) begin
                if (bus.set_quantum) begin
                    quantum = q_new;
                    left    = q_new;
                    enabled = (q_new > 0);
                end else if (bus.proc_halt && user) begin
                    pending = 1'b1;
                    enabled = 1'b0;
                end else if (bus.irq_ack) begin
                    left = quantum;
                end else if (bus.instr_retire && user) begin
                    left = left - 1;
                    if (left == 0) begin
                        pending = 1'b1;
                        enabled = 1'b0;
                    end
                end
            end else if (bus.set_quantum) begin
                quantum = q_new;
                left    = q_new;
                enabled = (q_new > 0);
            end
            m_left    <= left;
            m_quantum <= quantum;
            m_pending <= pending;
            m_enabled <= enabled;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        check("cyc_irq",       {31'd0, bus.irq},       {31'd0, m_pending});
        check("cyc_active",    {31'd0, bus.active},    {31'd0, m_pending | m_enabled});
        check("cyc_remaining", {16'd0, bus.remaining}, m_left);
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_q(input int q);
        bus.set_quantum = 1'b1;
        bus.quantum_in  = QW'(q);
        tick(1);
        bus.set_quantum = 1'b0;
    endtask

    task automatic retire(input int n);
        bus.instr_retire = 1'b1;
        tick(n);
        bus.instr_retire = 1'b0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
    endtask

    task automatic halt();
        bus.proc_halt = 1'b1;
        tick(1);
        bus.proc_halt = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        bus.set_quantum  = 1'b0;
        bus.quantum_in   = '0;
        bus.os_mode      = 1'b0;
        bus.instr_retire = 1'b0;
        bus.proc_halt    = 1'b0;
        bus.irq_ack      = 1'b0;

        // Reset values.
        #3;
        check("rst_irq", {31'd0, bus.irq}, 0);
        check("rst_remaining", {16'd0, bus.remaining}, 0);
        check("rst_active", {31'd0, bus.active}, 0);
        #9 reset_n = 1'b1;
        tick(1);

        // Quantum 3, three retires: 3,2,1,0 with irq one cycle after the last.
        set_q(3);
        check("q3_load", {16'd0, bus.remaining}, 3);
        check("q3_active", {31'd0, bus.active}, 1);
        retire(1);
        check("q3_r1", {16'd0, bus.remaining}, 2);
        retire(1);
        check("q3_r2", {16'd0, bus.remaining}, 1);
        check("q3_r2_irq", {31'd0, bus.irq}, 0);
        retire(1);
        check("q3_r3", {16'd0, bus.remaining}, 0);
        check("q3_expire_irq", {31'd0, bus.irq}, 1);
        check("q3_pend_active", {31'd0, bus.active}, 1);

        // Hold ack low for 5 cycles, then acknowledge.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("pend_hold_irq", {31'd0, bus.irq}, 1);
        end
        ack();
        check("ack_irq", {31'd0, bus.irq}, 0);
        check("ack_reload", {16'd0, bus.remaining}, 3);
        check("ack_active", {31'd0, bus.active}, 1);

        // Kernel mode suspends counting.
        set_q(5);
        bus.os_mode = 1'b1;
        retire(10);
        check("os_hold", {16'd0, bus.remaining}, 5);
        check("os_irq", {31'd0, bus.irq}, 0);
        halt();
        check("os_halt_ignored", {31'd0, bus.irq}, 0);
        bus.os_mode = 1'b0;
        retire(2);
        check("os_resume", {16'd0, bus.remaining}, 3);

        // Halt forces one request; a second halt in PEND is dropped.
        set_q(4);
        retire(1);
        halt();
        check("halt_irq", {31'd0, bus.irq}, 1);
        check("halt_frozen", {16'd0, bus.remaining}, 3);
        halt();
        retire(2);
        check("halt_again_irq", {31'd0, bus.irq}, 1);
        check("halt_again_rem", {16'd0, bus.remaining}, 3);
        ack();
        check("halt_ack_irq", {31'd0, bus.irq}, 0);
        check("halt_ack_rem", {16'd0, bus.remaining}, 4);
        tick(2);
        check("halt_no_requeue", {31'd0, bus.irq}, 0);

        // Voluntary context change in COUNT, then disable.
        set_q(4);
        retire(2);
        check("vol_before", {16'd0, bus.remaining}, 2);
        ack();
        check("vol_reload", {16'd0, bus.remaining}, 4);
        check("vol_irq", {31'd0, bus.irq}, 0);
        set_q(0);
        check("dis_active", {31'd0, bus.active}, 0);
        check("dis_rem", {16'd0, bus.remaining}, 0);
        retire(10);
        halt();
        ack();
        check("idle_irq", {31'd0, bus.irq}, 0);
        check("idle_active", {31'd0, bus.active}, 0);

        // Set Quantum together with ack in PEND.
        set_q(2);
        retire(2);
        check("sq_ack_pend", {31'd0, bus.irq}, 1);
        bus.set_quantum = 1'b1;
        bus.quantum_in  = QW'(7);
        bus.irq_ack     = 1'b1;
        tick(1);
        bus.set_quantum = 1'b0;
        bus.irq_ack     = 1'b0;
        check("sq_ack_rem", {16'd0, bus.remaining}, 7);
        check("sq_ack_active", {31'd0, bus.active}, 1);
        check("sq_ack_irq", {31'd0, bus.irq}, 0);

        // Set Quantum alone in PEND only changes the stored quantum.
        retire(7);
        check("pend_sq_pend", {31'd0, bus.irq}, 1);
        set_q(0);
        check("pend_sq_irq", {31'd0, bus.irq}, 1);
        ack();
        check("pend_sq0_idle", {31'd0, bus.active}, 0);

        // Maximum quantum.
        set_q(65535);
        retire(1);
        check("max_dec", {16'd0, bus.remaining}, 65534);

        // Asynchronous reset in the middle of a request.
        set_q(1);
        retire(1);
        check("arst_pend", {31'd0, bus.irq}, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_irq", {31'd0, bus.irq}, 0);
        check("arst_rem", {16'd0, bus.remaining}, 0);
        check("arst_active", {31'd0, bus.active}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/quantum_timer.md
Name: quantum_timer

Overview:
- Preemption timer for round-robin process scheduling; responder side of the processor's setQuantum / context-change path.
- The control unit pulses set_quantum when a Set Quantum instruction executes; this block loads the quantum and counts retired user-mode instructions.
- On expiry, or when a user process halts, it raises irq and holds it until the processor acknowledges with interruptionProcess (Change Context instruction).
- Sits beside the PC/jump logic; irq feeds the interrupt-entry mux.

Parameters:
- QWIDTH, 16, width of the quantum value and the down-counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- set_quantum  input  1  one-cycle pulse from the control unit's setQuantum.
- quantum_in  input  QWIDTH  quantum value (register operand); sampled when set_quantum=1.
- os_mode  input  1  1 while kernel/scheduler code runs; counting is suspended.
- instr_retire  input  1  one pulse per completed instruction.
- proc_halt  input  1  user process executed halt (control Halt=01); forces a request.
- irq_ack  input  1  the control unit's interruptionProcess; acknowledges a request.
- irq  output  1  context-change request, level, registered.
- remaining  output  QWIDTH  current down-counter value.
- active  output  1  1 when state is COUNT or PEND.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; quantum_reg=0; count=0; irq=0; remaining=0; active=0.
  - Reset mid-request drops irq immediately.
- States:
  - IDLE: timer disabled. Only set_quantum is honoured; retire, halt and ack are ignored.
  - COUNT: counting retired user-mode instructions.
  - PEND: irq=1, waiting for irq_ack.
- IDLE:
  - set_quantum with quantum_in!=0 -> quantum_reg=count=quantum_in, state COUNT.
  - set_quantum with quantum_in=0 -> stays IDLE, quantum_reg=0.
- COUNT, priority highest first:
  - set_quantum: quantum_in=0 -> IDLE, count=0. Otherwise quantum_reg=count=quantum_in, stay COUNT, no decrement that cycle.
  - proc_halt && !os_mode: -> PEND, irq=1 next cycle, count unchanged.
  - irq_ack (voluntary context change): count=quantum_reg, stay COUNT.
  - instr_retire && !os_mode && count==1: count=0 -> PEND, irq=1 on the following edge. Latency from the final retire to irq high is exactly 1 cycle.
  - instr_retire && !os_mode && count>1: count=count-1.
  - os_mode=1: count holds; retire is ignored.
- PEND:
  - irq stays 1 until irq_ack.
  - Further retire and proc_halt pulses are ignored; they are never queued, so a halt at expiry produces exactly one request.
  - set_quantum updates quantum_reg only (0 allowed); irq is unaffected.
  - irq_ack: irq=0 next cycle; if quantum_reg!=0, count=quantum_reg and state COUNT; else count=0 and state IDLE.
  - Ack and set_quantum in the same cycle: the new quantum_in is used for the reload and the IDLE/COUNT decision.
- Arithmetic and outputs:
  - count is unsigned QWIDTH and never wraps; 0 is reachable only via expiry, reset, or a disable.
  - Maximum quantum is 2^QWIDTH-1.
  - remaining mirrors count.
  - active is decoded from registered state, so it carries no combinational path from the inputs.

Test Plan:
- Reset, then set_quantum with quantum_in=3 and os_mode=0, then 3 retire pulses -> remaining steps 3,2,1,0; irq=1 exactly 1 cycle after the 3rd retire; active=1.
- Hold irq_ack low for 5 cycles while in PEND, then pulse irq_ack -> irq stays 1 throughout the hold; irq=0 the cycle after ack; remaining=3; state COUNT.
- Quantum 5, os_mode=1, 10 retire pulses -> remaining stays 5 and irq=0. Then os_mode=0 with 2 retire pulses -> remaining=3.
- Quantum 4, 1 retire, then proc_halt -> irq=1 next cycle with remaining=3. Pulse proc_halt again while in PEND -> no effect; one ack clears irq.
- Quantum 4 and 2 retires (remaining=2); pulse irq_ack in COUNT -> remaining=4, irq=0. Then set_quantum 0 -> IDLE, active=0; 10 retires leave irq=0.
- In PEND, set_quantum with quantum_in=7 in the same cycle as irq_ack -> remaining=7, state COUNT. Assert reset_n=0 mid-PEND -> irq=0 asynchronously, before the next clock edge.
